// File: rtl/arm_ldm_pkg.sv
// Shared definitions for the ARM LDM/STM block-transfer sequencer.
//   state_e    : sequencer FSM states
//   ldm_mode_e : addressing mode, encoded directly as {P,U}
//   R15_IDX    : register-list bit of the program counter
package arm_ldm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_e;

  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } ldm_mode_e;

  localparam int R15_IDX = 15;

  function automatic ldm_mode_e mode_of(input logic p, input logic u);
    return ldm_mode_e'({p, u});
  endfunction

endpackage

// File: rtl/ldm_lowest_set.sv
// Priority encoder: index and one-hot mask of the lowest set bit of list.
//   list : input vector (LIST_W)
//   idx  : index of the lowest set bit, 0 when list is empty (IDX_W)
//   mask : one-hot mask of that bit, all zero when list is empty (LIST_W)
module ldm_lowest_set #(
  parameter int LIST_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic [LIST_W-1:0] list,
  output logic [IDX_W-1:0]  idx,
  output logic [LIST_W-1:0] mask
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx  = '0;
    mask = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) begin
        idx     = IDX_W'(i);
        mask    = '0;
        mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_arm_ldm_seq.sv
// Multi-cycle LDM/STM sequencer. After start it issues one single-register
// beat per accepted handshake, then an optional base-writeback pulse.
//   start/reg_list/ldm_*/rn/base : instruction, sampled in IDLE
//   flush                        : abort, back to IDLE
//   beat_* / beat_ready          : valid/ready beat interface to the core
//   busy                         : upstream stall
//   branch/psr_restore           : r15 loaded (with S: SPSR->CPSR)
//   wb_en/wb_id/wb_value         : base writeback pulse
module decoder_arm_ldm_seq
  import arm_ldm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LIST_W     = 16,
  parameter int ID_W       = 5,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LIST_W-1:0] reg_list,
  input  logic              ldm_p,
  input  logic              ldm_u,
  input  logic              ldm_s,
  input  logic              ldm_w,
  input  logic              ldm_l,
  input  logic [3:0]        rn,
  input  logic [DATA_W-1:0] base,
  input  logic              flush,
  input  logic              beat_ready,
  output logic              busy,
  output logic              beat_valid,
  output logic [DATA_W-1:0] beat_addr,
  output logic              beat_rd_en,
  output logic              beat_wr_en,
  output logic [ID_W-1:0]   beat_reg_id,
  output logic              beat_user,
  output logic              beat_last,
  output logic              branch,
  output logic              psr_restore,
  output logic              wb_en,
  output logic [ID_W-1:0]   wb_id,
  output logic [DATA_W-1:0] wb_value
);

  localparam int CNT_W = $clog2(LIST_W + 1);
  // Widened list so rn and r15 can always be indexed, even for short lists.
  localparam int EXT_W = (LIST_W > 16) ? LIST_W : 16;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

  state_e            state;
  logic [LIST_W-1:0] list_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wb_value_r;
  logic [3:0]        rn_r;
  logic              load_r, user_r, pc_load_r, s_r, wb_pending_r;

  // Start-of-sequence arithmetic on the incoming instruction.
  logic [CNT_W-1:0]  n_cnt;
  logic [DATA_W-1:0] span, start_addr, wb_value_nxt;
  logic [EXT_W-1:0]  list_ext;

  always_comb begin
    n_cnt = '0;
    for (int i = 0; i < LIST_W; i++) begin
      if (reg_list[i]) n_cnt = n_cnt + CNT_W'(1);
    end
  end

  assign list_ext = EXT_W'(reg_list);
  assign span     = DATA_W'(n_cnt) * STEP;

  always_comb begin
    start_addr = base;
    unique case (mode_of(ldm_p, ldm_u))
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + STEP;
      MODE_DA: start_addr = base - span + STEP;
      MODE_DB: start_addr = base - span;
      default: start_addr = base;
    endcase
  end

  assign wb_value_nxt = ldm_u ? (base + span) : (base - span);

  // Current beat selection.
  logic [ID_W-1:0]   low_idx;
  logic [LIST_W-1:0] low_mask;
  logic              accept, start_ok;

  ldm_lowest_set #(
    .LIST_W(LIST_W),
    .IDX_W (ID_W)
  ) u_lowest (
    .list(list_r),
    .idx (low_idx),
    .mask(low_mask)
  );

  assign start_ok    = (state == S_IDLE) && start && !flush;
  assign beat_valid  = (state == S_ISSUE) && !flush;
  assign accept      = beat_valid && beat_ready;
  assign beat_last   = beat_valid && ((list_r & ~low_mask) == '0);
  assign beat_addr   = addr_r;
  assign beat_reg_id = low_idx;
  assign beat_rd_en  = beat_valid && load_r;
  assign beat_wr_en  = beat_valid && !load_r;
  assign beat_user   = beat_valid && user_r;
  assign branch      = accept && beat_last && pc_load_r;
  assign psr_restore = branch && s_r;
  assign busy        = (state != S_IDLE) || start_ok;
  assign wb_en       = (state == S_WB) && !flush;
  assign wb_id       = ID_W'(rn_r);
  assign wb_value    = wb_value_r;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      list_r       <= '0;
      addr_r       <= '0;
      wb_value_r   <= '0;
      rn_r         <= '0;
      load_r       <= 1'b0;
      user_r       <= 1'b0;
      pc_load_r    <= 1'b0;
      s_r          <= 1'b0;
      wb_pending_r <= 1'b0;
    end else if (flush) begin
      state  <= S_IDLE;
      list_r <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            list_r       <= reg_list;
            addr_r       <= start_addr;
            wb_value_r   <= wb_value_nxt;
            rn_r         <= rn;
            load_r       <= ldm_l;
            s_r          <= ldm_s;
            pc_load_r    <= ldm_l && list_ext[R15_IDX];
            user_r       <= ldm_s && !(ldm_l && list_ext[R15_IDX]);
            // A base register that is itself loaded suppresses writeback.
            wb_pending_r <= ldm_w && !(ldm_l && list_ext[rn]);
            state        <= (n_cnt == '0) ? S_IDLE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            list_r <= list_r & ~low_mask;
            addr_r <= addr_r + STEP;
            if (beat_last) state <= wb_pending_r ? S_WB : S_IDLE;
          end
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_arm_ldm_seq.sv
// Directed self-checking bench for decoder_arm_ldm_seq.
module tb_decoder_arm_ldm_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] reg_list;
  logic        ldm_p, ldm_u, ldm_s, ldm_w, ldm_l;
  logic [3:0]  rn;
  logic [31:0] base;
  logic        flush;
  logic        beat_ready;
  logic        busy, beat_valid, beat_rd_en, beat_wr_en, beat_user, beat_last;
  logic        branch, psr_restore, wb_en;
  logic [31:0] beat_addr, wb_value;
  logic [4:0]  beat_reg_id, wb_id;

  int n_assert = 0;
  int n_fail   = 0;

  decoder_arm_ldm_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reg_list(reg_list),
    .ldm_p(ldm_p), .ldm_u(ldm_u), .ldm_s(ldm_s), .ldm_w(ldm_w), .ldm_l(ldm_l),
    .rn(rn), .base(base), .flush(flush), .beat_ready(beat_ready),
    .busy(busy), .beat_valid(beat_valid), .beat_addr(beat_addr),
    .beat_rd_en(beat_rd_en), .beat_wr_en(beat_wr_en), .beat_reg_id(beat_reg_id),
    .beat_user(beat_user), .beat_last(beat_last), .branch(branch),
    .psr_restore(psr_restore), .wb_en(wb_en), .wb_id(wb_id), .wb_value(wb_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  64'(busy), 64'd0);
    check({tag, ".valid"}, 64'(beat_valid), 64'd0);
    check({tag, ".wb_en"}, 64'(wb_en), 64'd0);
    check({tag, ".branch"}, 64'(branch), 64'd0);
  endtask

  task automatic check_beat(input string tag, input logic [31:0] addr, input logic [4:0] id,
                            input logic rd, input logic last);
    check({tag, ".valid"}, 64'(beat_valid), 64'd1);
    check({tag, ".addr"},  64'(beat_addr), 64'(addr));
    check({tag, ".id"},    64'(beat_reg_id), 64'(id));
    check({tag, ".rd"},    64'(beat_rd_en), 64'(rd));
    check({tag, ".wr"},    64'(beat_wr_en), 64'(!rd));
    check({tag, ".last"},  64'(beat_last), 64'(last));
    check({tag, ".busy"},  64'(busy), 64'd1);
  endtask

  task automatic set_instr(input logic [15:0] lst, input logic p, input logic u, input logic s,
                           input logic w, input logic l, input logic [3:0] r, input logic [31:0] b);
    reg_list = lst; ldm_p = p; ldm_u = u; ldm_s = s; ldm_w = w; ldm_l = l; rn = r; base = b;
  endtask

  initial begin
    logic [4:0]  ids2 [3];
    logic [31:0] adr2 [3];
    ids2 = '{5'd1, 5'd2, 5'd15};
    adr2 = '{32'h1FF4, 32'h1FF8, 32'h1FFC};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; beat_ready = 1'b0;
    set_instr(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    #3;
    check_idle("reset");
    check("reset.addr", 64'(beat_addr), 64'd0);
    check("reset.wb_value", 64'(wb_value), 64'd0);
    check("reset.wb_id", 64'(wb_id), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // STMIA base=0x1000, r0..r3, writeback into r13
    set_instr(16'h000F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 32'h1000);
    beat_ready = 1'b1; start = 1'b1; #1;
    check("stmia.c0.busy", 64'(busy), 64'd1);
    check("stmia.c0.valid", 64'(beat_valid), 64'd0);
    tick(); start = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check_beat("stmia", 32'h1000 + 32'(4 * i), 5'(i), 1'b0, i == 3);
      check("stmia.user", 64'(beat_user), 64'd0);
      check("stmia.branch", 64'(branch), 64'd0);
      tick();
    end
    check("stmia.c5.valid", 64'(beat_valid), 64'd0);
    check("stmia.c5.wb_en", 64'(wb_en), 64'd1);
    check("stmia.c5.wb_value", 64'(wb_value), 64'h1010);
    check("stmia.c5.wb_id", 64'(wb_id), 64'd13);
    check("stmia.c5.busy", 64'(busy), 64'd1);
    tick();
    check_idle("stmia.c6");

    // LDMDB base=0x2000, {r1,r2,r15}, S=1
    set_instr(16'h8006, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h2000);
    start = 1'b1; #1;
    check("ldmdb.c0.busy", 64'(busy), 64'd1);
    tick(); start = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      check_beat("ldmdb", adr2[k], ids2[k], 1'b1, k == 2);
      check("ldmdb.user", 64'(beat_user), 64'd0);
      check("ldmdb.branch", 64'(branch), 64'(k == 2));
      check("ldmdb.psr", 64'(psr_restore), 64'(k == 2));
      tick();
    end
    check_idle("ldmdb.after");
    check("ldmdb.after.psr", 64'(psr_restore), 64'd0);

    // LDMIB rn=2 with r2 in list: base loaded, so no writeback
    set_instr(16'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h100);
    start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    check_beat("ldmib.b0", 32'h104, 5'd1, 1'b1, 1'b0);
    tick();
    check_beat("ldmib.b1", 32'h108, 5'd2, 1'b1, 1'b1);
    check("ldmib.branch", 64'(branch), 64'd0);
    tick();
    check_idle("ldmib.c3");
    tick();
    check("ldmib.c4.wb_en", 64'(wb_en), 64'd0);

    // Backpressure: STMIA {r0,r1}, ready 0,1,0,1
    set_instr(16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h3000);
    start = 1'b1; #1;
    tick(); start = 1'b0; beat_ready = 1'b0; #1;
    check_beat("bp.hold0", 32'h3000, 5'd0, 1'b0, 1'b0);
    tick(); beat_ready = 1'b1; #1;
    check_beat("bp.acc0", 32'h3000, 5'd0, 1'b0, 1'b0);
    tick(); beat_ready = 1'b0; #1;
    check_beat("bp.hold1", 32'h3004, 5'd1, 1'b0, 1'b1);
    tick(); beat_ready = 1'b1; #1;
    check_beat("bp.acc1", 32'h3004, 5'd1, 1'b0, 1'b1);
    tick();
    check_idle("bp.after");

    // Empty list: busy for the start cycle only, nothing else
    set_instr(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h7000);
    start = 1'b1; #1;
    check("empty.c0.busy", 64'(busy), 64'd1);
    check("empty.c0.valid", 64'(beat_valid), 64'd0);
    tick(); start = 1'b0; #1;
    check_idle("empty.c1");
    tick();
    check_idle("empty.c2");

    // Flush on the second beat of LDMIA {r4..r7}, W=1
    set_instr(16'h00F0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h4000);
    start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    check_beat("flush.b0", 32'h4000, 5'd4, 1'b1, 1'b0);
    tick();
    check_beat("flush.b1", 32'h4004, 5'd5, 1'b1, 1'b0);
    flush = 1'b1; #1;
    check("flush.valid", 64'(beat_valid), 64'd0);
    check("flush.branch", 64'(branch), 64'd0);
    check("flush.wb_en", 64'(wb_en), 64'd0);
    tick(); flush = 1'b0; #1;
    check_idle("flush.c3");
    tick();
    check_idle("flush.c4");

    // STMDA with S=1, then async reset mid-ISSUE
    set_instr(16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 32'h5000);
    start = 1'b1; #1;
    tick(); start = 1'b0; beat_ready = 1'b0; #1;
    check_beat("stmda.b0", 32'h4FFC, 5'd0, 1'b0, 1'b0);
    check("stmda.user", 64'(beat_user), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_idle("arst");
    check("arst.addr", 64'(beat_addr), 64'd0);
    check("arst.id", 64'(beat_reg_id), 64'd0);
    check("arst.rdwr", 64'({beat_rd_en, beat_wr_en}), 64'd0);
    check("arst.user_last", 64'({beat_user, beat_last}), 64'd0);
    check("arst.psr", 64'(psr_restore), 64'd0);
    check("arst.wb_id", 64'(wb_id), 64'd0);
    check("arst.wb_value", 64'(wb_value), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check_idle("arst.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_arm_ldm_seq.md
# decoder_arm_ldm_seq

Multi-cycle sequencer for ARM block data transfer (LDM/STM) that the single-cycle standard-op decoder does not execute. It sits beside the ARM standard decoder and, once an LDM/STM passes its condition check, emits one single-register memory beat per cycle. Each beat carries an address, a direction and a register id, handed to the core over a valid/ready handshake. Base writeback, a PC-load branch and the S-bit flags are generated here, and upstream issue is stalled while the block is busy.

## Interface
- `DATA_W`, default 32: address/base width.
- `LIST_W`, default 16: register-list width; `LIST_W <= 2**(ID_W-1)`.
- `ID_W`, default 5: register id width, same encoding as the core `rd_id`.
- `WORD_BYTES`, default 4: address step per beat.
- `clk`  in  1  core clock. One clock domain only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  `cmd_ldm & instruction_valid`; sampled only in IDLE.
- `reg_list`  in  LIST_W  instruction register list.
- `ldm_p`, `ldm_u`, `ldm_s`, `ldm_w`, `ldm_l`  in  1 each  pre-index, up, S-bit, writeback, load.
- `rn`  in  4  base register number.
- `base`  in  DATA_W  current value of Rn.
- `flush`  in  1  pipeline flush; aborts any sequence.
- `beat_ready`  in  1  core accepts the current beat.
- `busy`  out  1  stall to upstream decode.
- `beat_valid`  out  1  beat present.
- `beat_addr`  out  DATA_W  word address of the beat.
- `beat_rd_en`, `beat_wr_en`  out  1 each  load or store beat.
- `beat_reg_id`  out  ID_W  register to load or store, `{0, index}`.
- `beat_user`  out  1  user-bank transfer (S set and r15 not loaded).
- `beat_last`  out  1  final beat of the sequence.
- `branch`  out  1  r15 loaded; core discards the pipeline.
- `psr_restore`  out  1  copy SPSR to CPSR (LDM with S and r15 in list).
- `wb_en`  out  1  base writeback pulse.
- `wb_id`  out  ID_W  `{0, rn}`.
- `wb_value`  out  DATA_W  new base value.

## Operation
- FSM states: IDLE, ISSUE, WB.
- IDLE: when `start` is high, latch the list and flags, compute `n = popcount(reg_list)`, the start address and the writeback value.
  - Next state is ISSUE, or IDLE if `n == 0`.
  - An empty list produces no beats and no writeback.
- Start address, all arithmetic mod 2^DATA_W:
  - IA (P=0, U=1): `base`
  - IB (P=1, U=1): `base + WB`
  - DA (P=0, U=0): `base - n*WB + WB`
  - DB (P=1, U=0): `base - n*WB`
  - WB = WORD_BYTES.
- Writeback value: `U ? base + n*WB : base - n*WB`.
- ISSUE: `beat_reg_id` is the lowest set bit of the remaining list.
  - On `beat_valid & beat_ready`: clear that bit and add WB to the address.
  - `beat_valid` stays high and all beat fields stay stable until accepted.
- `beat_last` is high when exactly one bit remains.
- On acceptance of the last beat:
  - Next state is WB if `ldm_w` is set and not (`ldm_l & reg_list[rn]`).
  - Otherwise next state is IDLE. A loaded base wins over writeback.
- WB: one cycle with `wb_en=1`, then IDLE. No handshake.
- `branch` pulses together with acceptance of the last beat when `ldm_l & reg_list[15]`.
- `psr_restore` pulses on the same cycle when `ldm_s` is also set.
- `beat_user = ldm_s & ~(ldm_l & reg_list[15])`.
- `busy` is high in ISSUE and WB, and in the cycle `start` is accepted.
- `flush` in any state: next state is IDLE. In that cycle, `beat_valid`, `wb_en` and `branch` are forced to 0, and writeback is discarded.
- Reset: state IDLE; every output 0, including `busy`, `beat_addr`, `wb_value` and ids.

## Timing
- Cycle 0: `start` is sampled.
- Cycle 1: first beat is valid.
- With `beat_ready` held high, n beats occupy cycles 1..n. `wb_en` is high in cycle n+1, and `busy` falls after that cycle.
- `beat_ready` low inserts one wait cycle per low sample; the address does not advance.
- `start` while busy is ignored. The upstream decoder holds the instruction.
- `flush` takes priority over `beat_ready` in the same cycle. The beat is not counted as accepted.

## Structure
- Shared package `arm_ldm_pkg` holds:
  - the state enum;
  - the addressing-mode encoding (IA/IB/DA/DB from `{P,U}`);
  - the r15 index constant.
- Sub-module `ldm_lowest_set`: parametrised LIST_W priority encoder. Outputs the index and a one-hot mask of the lowest set bit.
- Popcount is inline combinational logic.

## Test plan
- STMIA, `base=0x1000`, `list=0x000F`, W=1, ready high:
  - beats r0..r3 at 0x1000, 0x1004, 0x1008, 0x100C with `wr_en=1`;
  - `beat_last` on r3;
  - cycle 5: `wb_en=1` with `wb_value=0x1010`.
- LDMDB, `base=0x2000`, `list=0x8006`, S=1:
  - beats r1 at 0x1FF4, r2 at 0x1FF8, r15 at 0x1FFC;
  - `branch=1` and `psr_restore=1` with the r15 beat;
  - `beat_user=0`.
- LDMIB, `rn=2`, `list=0x0006`, W=1, `base=0x100`:
  - beats at 0x104 and 0x108;
  - no `wb_en`, because the base is loaded.
- Backpressure: `list=0x0003`, `beat_ready` toggling 0,1,0,1:
  - each beat is held stable while `beat_ready=0`;
  - addresses advance only on acceptance.
- Empty list, `start=1`: `busy` high for one cycle, no `beat_valid`, no `wb_en`.
- Flush on the second beat of a 4-beat LDM with W=1 → IDLE next cycle, no `wb_en`. Async reset mid-ISSUE → all outputs 0 immediately.
